// File: rtl/posit_mul_pkg.sv
// Shared constants and arbiter state encoding for the posit multiplier front end.
package posit_mul_pkg;
   localparam int          POSIT_W   = 32;
   localparam logic [31:0] NAR_WORD  = 32'h8000_0000;
   localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RECOVER,
      ST_RESPOND
   } arb_state_e;
endpackage

// File: rtl/posit_mul_arbiter_rr_grant.sv
// Round-robin grant: first set request at or after ptr, wrapping, as one-hot plus index.
module rr_grant #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx
);
   always_comb begin
      int j;
      grant = '0;
      idx   = '0;
      j     = 0;
      for (int k = 0; k < N; k++) begin
         j = (int'(ptr) + k) % N;
         if (grant == '0 && req[j]) begin
            grant[j] = 1'b1;
            idx      = IW'(j);
         end
      end
   end
endmodule

// File: rtl/posit_mul_arbiter.sv
// Shares one posit multiplier core among N_REQ requesters, one operation in flight,
// with a watchdog that resets a hung core and answers NaR with rsp_err.
module posit_mul_arbiter
   import posit_mul_pkg::*;
#(
   parameter int N_REQ      = 4,
   parameter int TIMEOUT    = 64,
   parameter int RST_CYCLES = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_REQ-1:0]           req_valid,
   output logic [N_REQ-1:0]           req_ready,
   input  logic [32*N_REQ-1:0]        req_a,
   input  logic [32*N_REQ-1:0]        req_b,
   output logic                       core_start,
   output logic [31:0]                core_a,
   output logic [31:0]                core_b,
   output logic                       core_rst_n,
   input  logic                       core_done,
   input  logic [31:0]                core_result,
   input  logic                       core_nar,
   input  logic                       core_zero,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [$clog2(N_REQ)-1:0]   rsp_id,
   output logic [31:0]                rsp_result,
   output logic                       rsp_nar,
   output logic                       rsp_zero,
   output logic                       rsp_err
);
   localparam int IW = $clog2(N_REQ);
   localparam int TW = $clog2(TIMEOUT);
   localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

   arb_state_e       state;
   logic [IW-1:0]    ptr, id, gidx;
   logic [TW-1:0]    timer;
   logic [RW-1:0]    rcnt;
   logic [N_REQ-1:0] grant;

   rr_grant #(.N(N_REQ), .IW(IW)) u_rr (
      .req   (req_valid),
      .ptr   (ptr),
      .grant (grant),
      .idx   (gidx)
   );

   // No accepts while the core is still held in reset after rst.
   assign req_ready = (state == ST_IDLE && core_rst_n) ? grant : '0;
   assign rsp_id    = id;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         ptr        <= '0;
         id         <= '0;
         timer      <= '0;
         rcnt       <= '0;
         core_rst_n <= 1'b0;
         core_start <= 1'b0;
         core_a     <= '0;
         core_b     <= '0;
         rsp_valid  <= 1'b0;
         rsp_result <= '0;
         rsp_nar    <= 1'b0;
         rsp_zero   <= 1'b0;
         rsp_err    <= 1'b0;
      end else begin
         core_start <= 1'b0;
         case (state)
            ST_IDLE: begin
               core_rst_n <= 1'b1;
               if (|req_ready) begin
                  id         <= gidx;
                  core_a     <= req_a[gidx*POSIT_W +: POSIT_W];
                  core_b     <= req_b[gidx*POSIT_W +: POSIT_W];
                  core_start <= 1'b1;
                  state      <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               timer <= '0;
               state <= ST_WAIT;
            end
            ST_WAIT: begin
               // A done strobe in the timeout cycle still counts as a real result.
               if (core_done) begin
                  rsp_result <= core_result;
                  rsp_nar    <= core_nar;
                  rsp_zero   <= core_zero;
                  rsp_err    <= 1'b0;
                  rsp_valid  <= 1'b1;
                  state      <= ST_RESPOND;
               end else if (timer == TW'(TIMEOUT-1)) begin
                  rsp_result <= NAR_WORD;
                  rsp_nar    <= 1'b1;
                  rsp_zero   <= 1'b0;
                  rsp_err    <= 1'b1;
                  core_rst_n <= 1'b0;
                  rcnt       <= '0;
                  state      <= ST_RECOVER;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            ST_RECOVER: begin
               if (rcnt == RW'(RST_CYCLES-1)) begin
                  core_rst_n <= 1'b1;
                  rsp_valid  <= 1'b1;
                  state      <= ST_RESPOND;
               end else begin
                  rcnt <= rcnt + 1'b1;
               end
            end
            ST_RESPOND: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  ptr       <= (id == IW'(N_REQ-1)) ? '0 : id + 1'b1;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_posit_mul_arbiter.sv
// Scoreboard bench for posit_mul_arbiter with a behavioural multiplier-core stub.
module tb_posit_mul_arbiter;
   localparam int N  = 4;
   localparam int TO = 16;
   localparam int RC = 3;
   localparam logic [31:0] NAR = 32'h8000_0000;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [N-1:0]  req_valid = '0, req_ready;
   logic [32*N-1:0] req_a = '0, req_b = '0;
   logic          core_start, core_rst_n;
   logic [31:0]   core_a, core_b;
   logic          core_done = 1'b0, core_nar = 1'b0, core_zero = 1'b0;
   logic [31:0]   core_result = '0;
   logic          rsp_valid, rsp_ready = 1'b0;
   logic [1:0]    rsp_id;
   logic [31:0]   rsp_result;
   logic          rsp_nar, rsp_zero, rsp_err;

   int checks = 0, failures = 0;
   int lat = 6;
   bit hang = 0, inject = 0;

   typedef struct { logic [1:0] id; logic [31:0] res; logic nar, zero, err; } exp_t;
   exp_t sb[$];

   posit_mul_arbiter #(.N_REQ(N), .TIMEOUT(TO), .RST_CYCLES(RC)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .core_start(core_start), .core_a(core_a),
      .core_b(core_b), .core_rst_n(core_rst_n), .core_done(core_done),
      .core_result(core_result), .core_nar(core_nar), .core_zero(core_zero),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_result(rsp_result), .rsp_nar(rsp_nar), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
   );

   always #5 clk = ~clk;

   // Core stub behaviour: {nar, zero, result}
   function automatic logic [33:0] core_fn(input logic [31:0] a, input logic [31:0] b);
      if (a == NAR || b == NAR) return {2'b10, NAR};
      if (a == 32'h0 || b == 32'h0) return {2'b01, 32'h0};
      if (a == 32'h4000_0000) return {2'b00, b};
      return {2'b00, a + b};
   endfunction

   int cnt = 0;
   bit busy = 0;
   logic [31:0] la = '0, lb = '0;
   always @(negedge clk) begin
      core_done = 1'b0;
      if (core_rst_n === 1'b0) busy = 0;
      else if (core_start === 1'b1) begin busy = 1; cnt = lat; la = core_a; lb = core_b; end
      else if (busy) begin
         cnt--;
         if (cnt == 0) begin
            busy = 0;
            if (!hang) begin {core_nar, core_zero, core_result} = core_fn(la, lb); core_done = 1'b1; end
         end
      end
      if (inject && core_rst_n === 1'b1) begin
         core_done = 1'b1; core_result = 32'hDEAD_BEEF; core_nar = 1'b0; core_zero = 1'b0;
      end
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   function automatic string got_s();
      return $sformatf("id=%0d res=%h nar=%b zero=%b err=%b", rsp_id, rsp_result, rsp_nar, rsp_zero, rsp_err);
   endfunction
   function automatic string exp_s(input exp_t e);
      return $sformatf("id=%0d res=%h nar=%b zero=%b err=%b", e.id, e.res, e.nar, e.zero, e.err);
   endfunction

   task automatic step();
      @(negedge clk); #1;
   endtask

   task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
      req_valid[i] = 1'b1; req_a[32*i +: 32] = a; req_b[32*i +: 32] = b;
   endtask

   task automatic push_fn(input int i);
      logic [33:0] f;
      f = core_fn(req_a[32*i +: 32], req_b[32*i +: 32]);
      sb.push_back('{2'(i), f[31:0], f[33], f[32], 1'b0});
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = '1;
      step(); step(); step();
      checks++;
      if ({core_rst_n, core_start, rsp_valid, req_ready, core_a, core_b, rsp_result, rsp_nar, rsp_zero, rsp_err} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: got rst_n=%b start=%b rv=%b rdy=%b a=%h res=%h, want all 0",
                  core_rst_n, core_start, rsp_valid, req_ready, core_a, rsp_result);
      end
      req_valid = '0; rst = 1'b0;
      step();
      checks++;
      if (core_rst_n !== 1'b1) begin failures++; $display("FAIL reset_release: core_rst_n=%b want 1", core_rst_n); end
   endtask

   task automatic test_single();
      exp_t e; int n, starts;
      lat = 6; rsp_ready = 1'b0;
      set_req(0, 32'h4000_0000, 32'h4800_0000);
      sb.push_back('{2'd0, 32'h4800_0000, 1'b0, 1'b0, 1'b0});
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin failures++; $display("FAIL single_grant: got %b want 0001", req_ready); end
      step(); req_valid = '0;
      n = 0; starts = 0;
      while (!rsp_valid && n < 40) begin if (core_start) starts++; step(); n++; end
      checks++;
      if (n !== lat + 1) begin failures++; $display("FAIL single_latency: got %0d want %0d", n, lat + 1); end
      checks++;
      if (starts !== 1) begin failures++; $display("FAIL single_start_pulses: got %0d want 1", starts); end
      e = sb.pop_front();
      checks++;
      if ({rsp_valid, rsp_id, rsp_result, rsp_nar, rsp_zero, rsp_err} !== {1'b1, e.id, e.res, e.nar, e.zero, e.err}) begin
         failures++; $display("FAIL single_rsp: got v=%b %s want %s", rsp_valid, got_s(), exp_s(e));
      end
      rsp_ready = 1'b1;
      step();
      checks++;
      if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_rsp_drop: rsp_valid=%b want 0", rsp_valid); end
   endtask

   task automatic test_round_robin();
      exp_t e; int n; logic [3:0] eg;
      rst = 1'b1; step(); rst = 1'b0; step();
      lat = 3; rsp_ready = 1'b1;
      for (int i = 0; i < N; i++) set_req(i, 32'h0100_0000 * (i + 1) + i, 32'h0020_0000 + i);
      #1;
      for (int op = 0; op < 5; op++) begin
         n = 0;
         while (!(|(req_valid & req_ready)) && n < 30) begin step(); n++; end
         eg = 4'b0001 << (op % N);
         checks++;
         if (req_ready !== eg) begin failures++; $display("FAIL rr_grant op%0d: got %b want %b", op, req_ready, eg); end
         push_fn(op % N);
         step();
         n = 0;
         while (!rsp_valid && n < 30) begin step(); n++; end
         e = sb.pop_front();
         checks++;
         if ({rsp_valid, rsp_id, rsp_result, rsp_nar, rsp_zero, rsp_err} !== {1'b1, e.id, e.res, e.nar, e.zero, e.err}) begin
            failures++; $display("FAIL rr_rsp op%0d: got v=%b %s want %s", op, rsp_valid, got_s(), exp_s(e));
         end
         step();
      end
      req_valid = '0;
   endtask

   task automatic test_flags();
      exp_t e; int n;
      logic [31:0] fa [2] = '{32'h4000_0000, NAR};
      logic [31:0] fb [2] = '{32'h0000_0000, 32'h4000_0000};
      exp_t fe [2] = '{'{2'd2, 32'h0, 1'b0, 1'b1, 1'b0}, '{2'd2, NAR, 1'b1, 1'b0, 1'b0}};
      for (int k = 0; k < 2; k++) begin
         set_req(2, fa[k], fb[k]); #1;
         n = 0;
         while (!(|(req_valid & req_ready)) && n < 30) begin step(); n++; end
         checks++;
         if (req_ready !== 4'b0100) begin failures++; $display("FAIL flags_grant%0d: got %b want 0100", k, req_ready); end
         sb.push_back(fe[k]);
         step(); req_valid = '0;
         n = 0;
         while (!rsp_valid && n < 30) begin step(); n++; end
         e = sb.pop_front();
         checks++;
         if ({rsp_valid, rsp_id, rsp_result, rsp_nar, rsp_zero, rsp_err} !== {1'b1, e.id, e.res, e.nar, e.zero, e.err}) begin
            failures++; $display("FAIL flags_rsp%0d: got v=%b %s want %s", k, rsp_valid, got_s(), exp_s(e));
         end
         step();
      end
   endtask

   task automatic test_timeout();
      exp_t e; int n, lows;
      hang = 1;
      set_req(1, 32'h3000_0000, 32'h3800_0000); #1;
      checks++;
      if (req_ready !== 4'b0010) begin failures++; $display("FAIL wd_grant: got %b want 0010", req_ready); end
      sb.push_back('{2'd1, NAR, 1'b1, 1'b0, 1'b1});
      step(); req_valid = '0;
      n = 0; lows = 0;
      while (!rsp_valid && n < TO + 30) begin if (!core_rst_n) lows++; step(); n++; end
      checks++;
      if (n !== TO + 1 + RC) begin failures++; $display("FAIL wd_latency: got %0d want %0d", n, TO + 1 + RC); end
      checks++;
      if (lows !== RC || core_rst_n !== 1'b1) begin
         failures++; $display("FAIL wd_core_rst: low cycles %0d rst_n=%b want %0d and 1", lows, core_rst_n, RC);
      end
      e = sb.pop_front();
      checks++;
      if ({rsp_valid, rsp_id, rsp_result, rsp_nar, rsp_zero, rsp_err} !== {1'b1, e.id, e.res, e.nar, e.zero, e.err}) begin
         failures++; $display("FAIL wd_rsp: got v=%b %s want %s", rsp_valid, got_s(), exp_s(e));
      end
      step();
      hang = 0;
      set_req(3, 32'h3300_0000, 32'h0011_0000); #1;
      checks++;
      if (req_ready !== 4'b1000) begin failures++; $display("FAIL wd_next_grant: got %b want 1000", req_ready); end
      push_fn(3);
      step(); req_valid = '0;
      n = 0;
      while (!rsp_valid && n < 30) begin step(); n++; end
      e = sb.pop_front();
      checks++;
      if ({rsp_valid, rsp_id, rsp_result, rsp_nar, rsp_zero, rsp_err} !== {1'b1, e.id, e.res, e.nar, e.zero, e.err}) begin
         failures++; $display("FAIL wd_next_rsp: got v=%b %s want %s", rsp_valid, got_s(), exp_s(e));
      end
      step();
   endtask

   task automatic test_back_pressure();
      exp_t e; int n, bad;
      rsp_ready = 1'b0; lat = 4;
      set_req(0, 32'h3300_0000, 32'h4000_0000); #1;
      checks++;
      if (req_ready !== 4'b0001) begin failures++; $display("FAIL bp_grant: got %b want 0001", req_ready); end
      push_fn(0);
      step(); req_valid = '0;
      n = 0;
      while (!rsp_valid && n < 30) begin step(); n++; end
      e = sb.pop_front();
      req_valid = 4'b0010; #1;
      bad = 0;
      for (int c = 0; c < 10; c++) begin
         if (req_ready !== '0 ||
             {rsp_valid, rsp_id, rsp_result, rsp_nar, rsp_zero, rsp_err} !== {1'b1, e.id, e.res, e.nar, e.zero, e.err}) bad++;
         inject = (c % 3 == 0);
         step();
      end
      inject = 0; req_valid = '0;
      checks++;
      if (bad !== 0) begin failures++; $display("FAIL bp_stable: %0d unstable cycles, got %s want %s", bad, got_s(), exp_s(e)); end
      rsp_ready = 1'b1;
      step();
      checks++;
      if (rsp_valid !== 1'b0) begin failures++; $display("FAIL bp_release: rsp_valid=%b want 0", rsp_valid); end
   endtask

   task automatic test_rst_mid();
      exp_t e; int n;
      lat = 20; rsp_ready = 1'b1;
      set_req(2, 32'h3100_0000, 32'h3200_0000); #1;
      checks++;
      if (req_ready !== 4'b0100) begin failures++; $display("FAIL rm_grant: got %b want 0100", req_ready); end
      step(); req_valid = '0;
      step(); step(); step();
      rst = 1'b1; step();
      checks++;
      if ({rsp_valid, core_start, core_rst_n, req_ready, core_a, rsp_result, rsp_err} !== '0) begin
         failures++; $display("FAIL rm_reset: got rv=%b start=%b rst_n=%b rdy=%b a=%h, want all 0",
                              rsp_valid, core_start, core_rst_n, req_ready, core_a);
      end
      rst = 1'b0; lat = 3; step();
      set_req(0, 32'h3500_0000, 32'h0600_0000);
      set_req(3, 32'h3700_0000, 32'h0800_0000); #1;
      checks++;
      if (req_ready !== 4'b0001) begin failures++; $display("FAIL rm_ptr: got %b want 0001", req_ready); end
      push_fn(0);
      step(); req_valid = '0;
      n = 0;
      while (!rsp_valid && n < 40) begin step(); n++; end
      e = sb.pop_front();
      checks++;
      if ({rsp_valid, rsp_id, rsp_result, rsp_nar, rsp_zero, rsp_err} !== {1'b1, e.id, e.res, e.nar, e.zero, e.err}) begin
         failures++; $display("FAIL rm_rsp: got v=%b %s want %s", rsp_valid, got_s(), exp_s(e));
      end
      step();
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_flags();
      test_timeout();
      test_back_pressure();
      test_rst_mid();
      checks++;
      if (sb.size() !== 0) begin failures++; $display("FAIL sb_drain: %0d left want 0", sb.size()); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
